bi_mem_req_port: RTL



---
 rtl/bi_mem_pkg.sv | 20 ++
 rtl/bi_mem_rsp_fifo.sv | 54 +++++
 rtl/bi_mem_req_port.sv | 108 ++++++++++
 3 files changed

// File: rtl/bi_mem_pkg.sv
// Shared types for the BiMem request port: issue-register state and the
// default-sized request layout.
package bi_mem_pkg;

  localparam int unsigned ReqWidth  = 16;
  localparam int unsigned ReqHeight = 16;
  localparam int unsigned ReqAw     = $clog2(ReqHeight);

  typedef struct packed {
    logic             write;
    logic [ReqAw-1:0] addr;
    logic [ReqWidth-1:0] wdata;
  } req_t;

  typedef enum logic {
    ST_EMPTY,
    ST_PENDING
  } issue_state_e;

endpackage

// File: rtl/bi_mem_rsp_fifo.sv
// Response buffer: synchronous FIFO, outputs driven straight from state
// (head word forced to zero while empty).
module bi_mem_rsp_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rptr_q, wptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bi_mem_req_port.sv
// Valid/ready front end for BiMem: one-entry issue register, read-in-flight
// flag and credit counter guarding a response FIFO.
module bi_mem_req_port
  import bi_mem_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HEIGHT    = 16,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned AW       = $clog2(HEIGHT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             mem_enable_o,
  output logic             mem_isWrite_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_writeData_o,
  input  logic [WIDTH-1:0] mem_readData_i,
  input  logic             mem_hold_i
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } port_req_t;

  issue_state_e    state_q, state_d;
  port_req_t       req_q, req_d;
  logic            inflight_q, inflight_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic            taken, accept, rsp_pop, cnt_next_free;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;

  assign taken         = (state_q == ST_PENDING) && !mem_hold_i;
  assign rsp_pop       = rsp_valid_o && rsp_ready_i;
  assign cnt_after_pop = cnt_q - CntW'(rsp_pop);
  assign cnt_next_free = cnt_after_pop < CntW'(RSP_DEPTH);
  assign req_ready_o   = ((state_q == ST_EMPTY) || taken) && (req_write_i || cnt_next_free);
  assign accept        = req_valid_i && req_ready_o;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    inflight_d = taken && !req_q.write;
    // Credit is held from read accept until its response is popped.
    cnt_d      = cnt_after_pop + CntW'(accept && !req_write_i);
    if (accept) begin
      state_d     = ST_PENDING;
      req_d.write = req_write_i;
      req_d.addr  = req_addr_i;
      req_d.wdata = req_wdata_i;
    end else if (taken) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      req_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_enable_o    = (state_q == ST_PENDING);
  assign mem_isWrite_o   = req_q.write;
  assign mem_addr_o      = req_q.addr;
  assign mem_writeData_o = req_q.wdata;
  assign rsp_valid_o     = !fifo_empty;

  bi_mem_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i (mem_readData_i),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_rdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q == CntW'((state_q == ST_PENDING) && !req_q.write) + CntW'(inflight_q) + fifo_count);
  assert property (@(posedge clk_i) disable iff (rst_i)
    inflight_q |-> (!fifo_full || rsp_pop));

endmodule
